// File: rtl/ariscv_run_ctrl.sv
// Run/halt/step controller for the self-timed RISC-V ring.
// Gates PC token injection and tracks issue/retire via aclk pulses.
module ariscv_run_ctrl #(
  parameter int ACLK_NBW    = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int INFL_W      = 4,
  parameter int WDT_LIMIT   = 1024
) (
  input  logic                clk,
  input  logic                rst_async_n,
  input  logic [ACLK_NBW-1:0] i_aclk,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic [CNT_W-1:0]    i_step_cnt,
  output logic                o_ring_en,
  output logic [2:0]          o_state,
  output logic [CNT_W-1:0]    o_retired,
  output logic                o_halted,
  output logic                o_wdt_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_STEP  = 2'b11;

  localparam int WDT_W = $clog2(WDT_LIMIT + 1);
  localparam logic [INFL_W-1:0] INFL_MAX = {INFL_W{1'b1}};

  logic [SYNC_STAGES-1:0][ACLK_NBW-1:0] sync_q;
  logic [ACLK_NBW-1:0] prev_q;
  logic [ACLK_NBW-1:0] edge_q;

  state_t            state_q;
  state_t            nxt;
  logic [INFL_W-1:0] infl_q;
  logic [CNT_W-1:0]  step_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [WDT_W-1:0]  wdt_q;

  logic issue;
  logic retire;
  logic any_edge;
  logic accept;
  logic wdt_act;
  logic nxt_act;
  logic wdt_fire;
  logic step_load;
  logic clr_ret;
  logic clr_err;

  // Synchronizer chain plus registered rising-edge detect per bit
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      sync_q <= '0;
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_aclk};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign issue    = edge_q[0];
  assign retire   = edge_q[ACLK_NBW-1];
  assign any_edge = |edge_q;
  assign accept   = i_cmd_valid & o_cmd_ready;

  assign wdt_act = (state_q == S_RUN) ||
                   (state_q == S_STEP) ||
                   (state_q == S_DRAIN);
  assign nxt_act = (nxt == S_RUN) ||
                   (nxt == S_STEP) ||
                   (nxt == S_DRAIN);
  assign wdt_fire = wdt_act && !any_edge &&
                    (wdt_q == WDT_W'(WDT_LIMIT - 1));

  always_comb begin
    nxt       = state_q;
    step_load = 1'b0;
    clr_ret   = 1'b0;
    clr_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            i_cmd_op == OP_RUN: nxt = S_RUN;
            i_cmd_op == OP_STEP: begin
              if (i_step_cnt != '0) begin
                nxt       = S_STEP;
                step_load = 1'b1;
              end
            end
            i_cmd_op == OP_CLEAR: clr_ret = 1'b1;
            i_cmd_op == OP_HALT: ;
          endcase
        end
      end
      S_RUN: begin
        if (accept && i_cmd_op == OP_HALT)
          nxt = S_DRAIN;
      end
      S_STEP: begin
        if (issue_cnt_q == step_q)
          nxt = S_DRAIN;
        else if (accept && i_cmd_op == OP_HALT)
          nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (infl_q == '0)
          nxt = S_IDLE;
      end
      S_ERR: begin
        if (accept && i_cmd_op == OP_CLEAR) begin
          nxt     = S_IDLE;
          clr_ret = 1'b1;
          clr_err = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
    // Deadlock overrides any command this cycle
    if (wdt_fire)
      nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q     <= S_IDLE;
      o_ring_en   <= 1'b0;
      o_halted    <= 1'b1;
      o_cmd_ready <= 1'b1;
      o_wdt_err   <= 1'b0;
    end else begin
      state_q     <= nxt;
      o_ring_en   <= (nxt == S_RUN) || (nxt == S_STEP);
      o_halted    <= (nxt == S_IDLE);
      o_cmd_ready <= (nxt != S_DRAIN);
      o_wdt_err   <= (nxt == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      infl_q <= '0;
    end else if (clr_err) begin
      infl_q <= '0;
    end else if (issue && !retire) begin
      if (infl_q != INFL_MAX)
        infl_q <= infl_q + 1'b1;
    end else if (retire && !issue) begin
      if (infl_q != '0)
        infl_q <= infl_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      o_retired <= '0;
    end else if (clr_ret) begin
      o_retired <= '0;
    end else if (retire) begin
      o_retired <= o_retired + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      step_q      <= '0;
      issue_cnt_q <= '0;
    end else if (step_load) begin
      step_q      <= i_step_cnt;
      issue_cnt_q <= '0;
    end else if (issue && state_q == S_STEP) begin
      issue_cnt_q <= issue_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n)
      wdt_q <= '0;
    else if (wdt_act && nxt_act && !any_edge)
      wdt_q <= wdt_q + 1'b1;
    else
      wdt_q <= '0;
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_ariscv_run_ctrl.sv
// Directed bench for ariscv_run_ctrl.
// Bench plays the ring: drives aclk pulses and host commands.
module tb_ariscv_run_ctrl;

  localparam int NBW = 6;
  localparam int CW  = 16;
  localparam int WDT = 40;

  logic           clk = 1'b0;
  logic           rst_async_n = 1'b0;
  logic [NBW-1:0] i_aclk = '0;
  logic           i_cmd_valid = 1'b0;
  logic           o_cmd_ready;
  logic [1:0]     i_cmd_op = 2'b00;
  logic [CW-1:0]  i_step_cnt = '0;
  logic           o_ring_en;
  logic [2:0]     o_state;
  logic [CW-1:0]  o_retired;
  logic           o_halted;
  logic           o_wdt_err;

  int n_run = 0;
  int n_fail = 0;
  int n_iss;

  always #5 clk = ~clk;

  ariscv_run_ctrl #(
    .ACLK_NBW(NBW),
    .SYNC_STAGES(2),
    .CNT_W(CW),
    .INFL_W(4),
    .WDT_LIMIT(WDT)
  ) dut (
    .clk(clk),
    .rst_async_n(rst_async_n),
    .i_aclk(i_aclk),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op),
    .i_step_cnt(i_step_cnt),
    .o_ring_en(o_ring_en),
    .o_state(o_state),
    .o_retired(o_retired),
    .o_halted(o_halted),
    .o_wdt_err(o_wdt_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [CW-1:0] cnt);
    i_cmd_op    = op;
    i_step_cnt  = cnt;
    i_cmd_valid = 1'b1;
    tick(1);
    i_cmd_valid = 1'b0;
  endtask

  // One instruction period: 1-cycle pulse then 5 quiet cycles
  task automatic pulse(input logic [NBW-1:0] m);
    i_aclk = m;
    tick(1);
    i_aclk = '0;
    tick(5);
  endtask

  initial begin
    tick(3);
    rst_async_n = 1'b1;
    tick(1);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_ring", 32'(o_ring_en), 0);
    chk("rst_halt", 32'(o_halted), 1);
    chk("rst_wdt", 32'(o_wdt_err), 0);
    chk("rst_ret", 32'(o_retired), 0);
    chk("rst_rdy", 32'(o_cmd_ready), 1);

    cmd(2'b01, '0);
    chk("run_ring", 32'(o_ring_en), 1);
    chk("run_state", 32'(o_state), 1);
    chk("run_halt", 32'(o_halted), 0);
    for (int i = 0; i < 10; i++) begin
      pulse(6'b000001);
      pulse(6'b100000);
    end
    chk("run_ret10", 32'(o_retired), 10);
    chk("run_infl0", 32'(dut.infl_q), 0);
    cmd(2'b10, '0);
    tick(1);
    chk("halt0_idle", 32'(o_state), 0);
    cmd(2'b00, '0);
    chk("clr_ret", 32'(o_retired), 0);

    cmd(2'b11, 16'd3);
    chk("step_state", 32'(o_state), 2);
    chk("step_ring", 32'(o_ring_en), 1);
    n_iss = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_ring_en) begin
        pulse(6'b000001);
        n_iss++;
      end
    end
    chk("step_issues", 32'(n_iss), 3);
    chk("step_drain", 32'(o_state), 3);
    chk("step_rdy", 32'(o_cmd_ready), 0);
    pulse(6'b100000);
    pulse(6'b100000);
    chk("step_drain2", 32'(o_state), 3);
    pulse(6'b100000);
    chk("step_idle", 32'(o_state), 0);
    chk("step_halted", 32'(o_halted), 1);
    chk("step_ret3", 32'(o_retired), 3);

    cmd(2'b01, '0);
    pulse(6'b000001);
    pulse(6'b000001);
    cmd(2'b10, '0);
    chk("hd_state", 32'(o_state), 3);
    chk("hd_rdy", 32'(o_cmd_ready), 0);
    chk("hd_ring", 32'(o_ring_en), 0);
    cmd(2'b01, '0);
    chk("hd_norun", 32'(o_state), 3);
    pulse(6'b100000);
    chk("hd_drain1", 32'(o_state), 3);
    chk("hd_rdy1", 32'(o_cmd_ready), 0);
    pulse(6'b100000);
    chk("hd_idle", 32'(o_state), 0);
    chk("hd_rdy2", 32'(o_cmd_ready), 1);
    chk("hd_ret5", 32'(o_retired), 5);

    cmd(2'b01, '0);
    tick(WDT - 1);
    chk("wdt_pre", 32'(o_state), 1);
    chk("wdt_pre_err", 32'(o_wdt_err), 0);
    tick(1);
    chk("wdt_state", 32'(o_state), 4);
    chk("wdt_err", 32'(o_wdt_err), 1);
    chk("wdt_ring", 32'(o_ring_en), 0);
    cmd(2'b01, '0);
    chk("err_norun", 32'(o_state), 4);
    cmd(2'b00, '0);
    chk("err_clr", 32'(o_state), 0);
    chk("err_clr_w", 32'(o_wdt_err), 0);
    chk("err_clr_r", 32'(o_retired), 0);
    chk("err_halt", 32'(o_halted), 1);

    cmd(2'b01, '0);
    pulse(6'b000001);
    chk("sim_infl1", 32'(dut.infl_q), 1);
    pulse(6'b100001);
    chk("sim_infl", 32'(dut.infl_q), 1);
    chk("sim_ret1", 32'(o_retired), 1);
    pulse(6'b100000);
    chk("sim_infl0", 32'(dut.infl_q), 0);
    chk("sim_ret2", 32'(o_retired), 2);
    cmd(2'b10, '0);
    tick(1);
    chk("sim_idle", 32'(o_state), 0);
    cmd(2'b11, 16'd0);
    chk("step0_st", 32'(o_state), 0);
    chk("step0_ring", 32'(o_ring_en), 0);

    cmd(2'b11, 16'd5);
    pulse(6'b000001);
    chk("mid_state", 32'(o_state), 2);
    chk("mid_ring", 32'(o_ring_en), 1);
    #3;
    rst_async_n = 1'b0;
    #1;
    chk("ar_ring", 32'(o_ring_en), 0);
    chk("ar_state", 32'(o_state), 0);
    chk("ar_halt", 32'(o_halted), 1);
    chk("ar_ret", 32'(o_retired), 0);
    chk("ar_rdy", 32'(o_cmd_ready), 1);
    chk("ar_wdt", 32'(o_wdt_err), 0);
    tick(2);
    rst_async_n = 1'b1;
    tick(2);
    chk("post_rst", 32'(o_state), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
